// File: rtl/eim_da_phy_pkg.sv
// Shared definitions for the EIM data-bus PHY pipe: FSM state encoding and
// parameter limits.
package eim_da_phy_pkg;

   typedef enum logic [1:0] {
      ST_RX      = 2'd0,
      ST_TURN_TX = 2'd1,
      ST_TX      = 2'd2
   } phy_state_e;

   localparam int BUS_WIDTH_MIN   = 1;
   localparam int BUS_WIDTH_MAX   = 32;
   localparam int IN_STAGES_MIN   = 1;
   localparam int IN_STAGES_MAX   = 4;
   localparam int TURN_CYCLES_MAX = 7;
   localparam int CNT_W           = 3;

endpackage

// File: rtl/eim_da_phy_capture.sv
// Receive capture pipeline: pin samples and their valid bits shift through
// IN_STAGES registers together.
module eim_da_phy_capture
   import eim_da_phy_pkg::*;
#(
   parameter int BUS_WIDTH = 16,
   parameter int IN_STAGES = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [BUS_WIDTH-1:0] i_data,
   input  logic                 i_vld,
   output logic [BUS_WIDTH-1:0] o_data,
   output logic                 o_vld,
   output logic [BUS_WIDTH-1:0] o_first
);

   logic [BUS_WIDTH-1:0] r_data [IN_STAGES];
   logic [IN_STAGES-1:0] r_vld;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < IN_STAGES; i++) begin
            r_data[i] <= '0;
         end
         r_vld <= '0;
      end else begin
         r_data[0] <= i_data;
         r_vld[0]  <= i_vld;
         for (int i = 1; i < IN_STAGES; i++) begin
            r_data[i] <= r_data[i-1];
            r_vld[i]  <= r_vld[i-1];
         end
      end
   end

   assign o_data  = r_data[IN_STAGES-1];
   assign o_vld   = r_vld[IN_STAGES-1];
   assign o_first = r_data[0];

endmodule

// File: rtl/eim_da_phy_pipe.sv
// Bidirectional EIM data-bus PHY with turnaround FSM and receive pipeline.
// Optional contention detector enabled by macro EIM_DA_PHY_PIPE_CONTENTION_EN.
module eim_da_phy_pipe
   import eim_da_phy_pkg::*;
#(
   parameter int BUS_WIDTH   = 16,
   parameter int IN_STAGES   = 2,
   parameter int TURN_CYCLES = 1
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   inout  wire  [BUS_WIDTH-1:0] buf_io,
   input  logic [BUS_WIDTH-1:0] buf_di,
   input  logic                 buf_t,
   output logic [BUS_WIDTH-1:0] buf_ro,
   output logic                 buf_ro_valid,
   output logic                 drive_active,
   output logic                 turn_busy,
   input  logic                 err_clr,
   output logic                 contention_err
);

   if (BUS_WIDTH < BUS_WIDTH_MIN || BUS_WIDTH > BUS_WIDTH_MAX ||
       IN_STAGES < IN_STAGES_MIN || IN_STAGES > IN_STAGES_MAX ||
       TURN_CYCLES < 0 || TURN_CYCLES > TURN_CYCLES_MAX) begin : g_bad_param
      $error("eim_da_phy_pipe: parameter out of range");
   end

   localparam bit              LP_HAS_TURN = (TURN_CYCLES > 0);
   localparam logic [CNT_W-1:0] LP_CNT_LOAD = LP_HAS_TURN ? CNT_W'(TURN_CYCLES - 1) : '0;

   phy_state_e           r_state, w_state_nxt;
   logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
   logic [BUS_WIDTH-1:0] r_dout;
   logic                 r_prev_tx;
   logic                 w_vld_in;
   logic [BUS_WIDTH-1:0] w_cap0;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_RX: begin
            if (!buf_t) begin
               if (LP_HAS_TURN) begin
                  w_state_nxt = ST_TURN_TX;
                  w_cnt_nxt   = LP_CNT_LOAD;
               end else begin
                  w_state_nxt = ST_TX;
               end
            end
         end
         ST_TURN_TX: begin
            if (buf_t) begin
               w_state_nxt = ST_RX;
               w_cnt_nxt   = '0;
            end else if (r_cnt == '0) begin
               w_state_nxt = ST_TX;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         ST_TX: begin
            if (buf_t) w_state_nxt = ST_RX;
         end
         default: begin
            w_state_nxt = ST_RX;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state   <= ST_RX;
         r_cnt     <= '0;
         r_dout    <= '0;
         r_prev_tx <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_dout    <= buf_di;
         r_prev_tx <= (r_state == ST_TX);
      end
   end

   // Enable comes straight from the state register, so release happens on the edge leaving TX.
   assign drive_active = (r_state == ST_TX);
   assign turn_busy    = (r_state == ST_TURN_TX);
   assign buf_io       = drive_active ? r_dout : {BUS_WIDTH{1'bz}};

   // A sample is trusted only if the bus was released for that whole cycle and not just released.
   assign w_vld_in = (r_state == ST_RX) && !r_prev_tx;

   eim_da_phy_capture #(
      .BUS_WIDTH (BUS_WIDTH),
      .IN_STAGES (IN_STAGES)
   ) u_capture (
      .i_clk   (sys_clk),
      .i_rst   (sys_rst),
      .i_data  (buf_io),
      .i_vld   (w_vld_in),
      .o_data  (buf_ro),
      .o_vld   (buf_ro_valid),
      .o_first (w_cap0)
   );

`ifdef EIM_DA_PHY_PIPE_CONTENTION_EN
   logic [BUS_WIDTH-1:0] r_dout_prev;
   logic                 r_err;
   logic                 w_mismatch;

   assign w_mismatch = (r_state == ST_TX) && r_prev_tx && (w_cap0 != r_dout_prev);

   always_ff @(posedge sys_clk) begin
      r_dout_prev <= r_dout;
      if (sys_rst) begin
         r_err <= 1'b0;
      end else if (w_mismatch) begin
         r_err <= 1'b1;
      end else if (err_clr) begin
         r_err <= 1'b0;
      end
   end

   assign contention_err = r_err;
`else
   logic w_unused;
   assign w_unused       = ^{err_clr, w_cap0};
   assign contention_err = 1'b0;
`endif

endmodule
